// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: one radix-2 shift-add or restoring-divide
// step per cycle over sign-stripped magnitudes, sign fixed up in the final cycle.
module muldiv_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            start_i,
   input  logic            abort_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] rs1_val_i,
   input  logic [XLEN-1:0] rs2_val_i,
   input  logic [4:0]      rd_in_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o,
   output logic [4:0]      rd_out_o
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [2:0]        f3_q;
   logic [4:0]        rd_q, rd_out_q;
   logic              neg_q, busy_q, done_q;
   logic [XLEN-1:0]   opnd_q, hi_q, lo_q, result_q;

   logic              a_sgn, b_sgn, neg_d;
   logic [XLEN-1:0]   a_mag, b_mag, hi_d, lo_d;
   logic [XLEN:0]     mul_sum, div_shift;
   logic [2*XLEN-1:0] prod_c;
   logic [XLEN-1:0]   q_c, r_c, res_d;

   // Operand conditioning at acceptance: magnitudes plus the final sign flag
   always_comb begin
      a_sgn = rs1_val_i[XLEN-1] & (funct3_i[2] ? ~funct3_i[0] : (funct3_i[1:0] != 2'b11));
      b_sgn = rs2_val_i[XLEN-1] & (funct3_i[2] ? ~funct3_i[0] : ~funct3_i[1]);
      a_mag = a_sgn ? -rs1_val_i : rs1_val_i;
      b_mag = b_sgn ? -rs2_val_i : rs2_val_i;
      // a zero divisor must leave the all-ones quotient unnegated
      if (funct3_i[2])
         neg_d = funct3_i[1] ? a_sgn : ((a_sgn ^ b_sgn) & (|rs2_val_i));
      else
         neg_d = a_sgn ^ b_sgn;
   end

   // hi_q:lo_q is the product for multiply, remainder:quotient for divide
   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
      div_shift = {hi_q, lo_q[XLEN-1]};
      if (f3_q[2]) begin
         if (div_shift >= {1'b0, opnd_q}) begin
            hi_d = XLEN'(div_shift - {1'b0, opnd_q});
            lo_d = {lo_q[XLEN-2:0], 1'b1};
         end else begin
            hi_d = div_shift[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b0};
         end
      end else begin
         hi_d = mul_sum[XLEN:1];
         lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
      end
   end

   always_comb begin
      prod_c = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
      q_c    = neg_q ? -lo_q : lo_q;
      r_c    = neg_q ? -hi_q : hi_q;
      if (f3_q[2])
         res_d = f3_q[1] ? r_c : q_c;
      else
         res_d = (f3_q[1:0] == 2'b00) ? prod_c[XLEN-1:0] : prod_c[2*XLEN-1:XLEN];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         f3_q     <= '0;
         rd_q     <= '0;
         rd_out_q <= '0;
         neg_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         opnd_q   <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         result_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_i && !abort_i && !done_q) begin
                  f3_q    <= funct3_i;
                  rd_q    <= rd_in_i;
                  neg_q   <= neg_d;
                  opnd_q  <= funct3_i[2] ? b_mag : a_mag;
                  lo_q    <= funct3_i[2] ? a_mag : b_mag;
                  hi_q    <= '0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= CALC;
               end
            end
            CALC: begin
               if (abort_i) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  hi_q  <= hi_d;
                  lo_q  <= lo_d;
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_W'(XLEN-1)) state_q <= DONE;
               end
            end
            DONE: begin
               if (!abort_i) begin
                  result_q <= res_d;
                  rd_out_q <= rd_q;
                  done_q   <= 1'b1;
               end
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy_o   = busy_q;
   assign done_o   = done_q;
   assign result_o = result_q;
   assign rd_out_o = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed table, randomized ops against an arithmetic
// reference model, and handshake/abort/reset sequences.
module tb_muldiv_unit;

   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
   logic [2:0]  f3 = '0;
   logic [31:0] a = '0, b = '0;
   logic [4:0]  rd = '0;
   logic        busy, done;
   logic [31:0] result;
   logic [4:0]  rd_out;

   muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
      .funct3_i(f3), .rs1_val_i(a), .rs2_val_i(b), .rd_in_i(rd),
      .busy_o(busy), .done_o(done), .result_o(result), .rd_out_o(rd_out)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_err = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
      longint      sx, sy, uy;
      logic [63:0] p;
      logic        ovf;
      logic [31:0] r;
      sx  = longint'($signed(x));
      sy  = longint'($signed(y));
      uy  = longint'({32'b0, y});
      ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
      case (f)
         3'd0: begin p = 64'(sx * sy); r = p[31:0]; end
         3'd1: begin p = 64'(sx * sy); r = p[63:32]; end
         3'd2: begin p = 64'(sx * uy); r = p[63:32]; end
         3'd3: begin p = {32'b0, x} * {32'b0, y}; r = p[63:32]; end
         3'd4: r = (y == 0) ? 32'hFFFF_FFFF : ovf ? x : 32'(sx / sy);
         3'd5: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
         3'd6: r = (y == 0) ? x : ovf ? 32'd0 : 32'(sx % sy);
         default: r = (y == 0) ? x : x % y;
      endcase
      return r;
   endfunction

   // Issue one op, scramble inputs while it runs, return result and latency
   task automatic run_op(input logic [2:0] fv, input logic [31:0] av, input logic [31:0] bv,
                         input logic [4:0] rdv, output logic [31:0] res, output logic [4:0] rdo,
                         output int lat);
      @(negedge clk);
      f3 = fv; a = av; b = bv; rd = rdv; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      while (!done && lat < 60) begin
         a = $urandom; b = $urandom; f3 = 3'($urandom); rd = 5'($urandom);
         @(negedge clk);
         lat++;
      end
      res = result;
      rdo = rd_out;
   endtask

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a, b;
      logic [4:0]  rd;
      logic [31:0] exp;
   } vec_t;

   vec_t        tbl[16];
   logic [31:0] special[5];

   initial begin
      logic [31:0] res, keep;
      logic [4:0]  rdo;
      int          lat, seen, when;
      logic [2:0]  rf;
      logic [31:0] ra, rb;
      logic [4:0]  rr;

      tbl[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB};
      tbl[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 5'd1,  32'h4000_0000};
      tbl[2]  = '{3'd2, 32'h8000_0000,  32'h8000_0000, 5'd2,  32'hC000_0000};
      tbl[3]  = '{3'd3, 32'h8000_0000,  32'h8000_0000, 5'd3,  32'h4000_0000};
      tbl[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         5'd4,  32'hFFFF_FFFD};
      tbl[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         5'd6,  32'hFFFF_FFFF};
      tbl[6]  = '{3'd5, 32'd100,        32'd7,         5'd7,  32'd14};
      tbl[7]  = '{3'd7, 32'd100,        32'd7,         5'd8,  32'd2};
      tbl[8]  = '{3'd4, 32'h1234,       32'd0,         5'd9,  32'hFFFF_FFFF};
      tbl[9]  = '{3'd5, 32'h1234,       32'd0,         5'd10, 32'hFFFF_FFFF};
      tbl[10] = '{3'd6, 32'h1234,       32'd0,         5'd11, 32'h1234};
      tbl[11] = '{3'd7, 32'h1234,       32'd0,         5'd12, 32'h1234};
      tbl[12] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd13, 32'h8000_0000};
      tbl[13] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd14, 32'd0};
      tbl[14] = '{3'd4, 32'hFFFF_FFF9,  32'd0,         5'd15, 32'hFFFF_FFFF};
      tbl[15] = '{3'd6, 32'hFFFF_FFF9,  32'd0,         5'd31, 32'hFFFF_FFF9};
      special = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

      repeat (3) @(negedge clk);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_result", result, 32'd0);
      check("reset_rd_out", 32'(rd_out), 32'd0);
      rst_n = 1'b1;

      // Cycle-exact busy/done trace of the first MUL
      @(negedge clk);
      f3 = 3'd0; a = 32'd7; b = 32'hFFFF_FFFD; rd = 5'd5; start = 1'b1;
      for (int k = 0; k <= 34; k++) begin
         @(negedge clk);
         start = 1'b0;
         check($sformatf("trace_busy_k%0d", k), 32'(busy), (k <= 32) ? 32'd1 : 32'd0);
         check($sformatf("trace_done_k%0d", k), 32'(done), (k == 33) ? 32'd1 : 32'd0);
         if (k == 33) begin
            check("trace_result", result, 32'hFFFF_FFEB);
            check("trace_rd_out", 32'(rd_out), 32'd5);
         end
      end

      for (int i = 0; i < 16; i++) begin
         run_op(tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].rd, res, rdo, lat);
         check($sformatf("tbl%0d_result", i), res, tbl[i].exp);
         check($sformatf("tbl%0d_rd", i), 32'(rdo), 32'(tbl[i].rd));
         check($sformatf("tbl%0d_latency", i), 32'(lat), 32'd33);
      end

      for (int i = 0; i < 60; i++) begin
         rf = 3'($urandom);
         ra = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 4)] : $urandom;
         rb = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 4)] : $urandom;
         rr = 5'($urandom);
         run_op(rf, ra, rb, rr, res, rdo, lat);
         check($sformatf("rnd%0d_f%0d_%h_%h", i, rf, ra, rb), res, ref_model(rf, ra, rb));
         check($sformatf("rnd%0d_rd", i), 32'(rdo), 32'(rr));
         if (lat != 33) check($sformatf("rnd%0d_latency", i), 32'(lat), 32'd33);
      end

      // Start during the done cycle is ignored
      run_op(3'd5, 32'd100, 32'd7, 5'd3, res, rdo, lat);
      f3 = 3'd0; a = 32'd3; b = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("done_cycle_start_busy", 32'(busy), 32'd0);
      check("done_cycle_start_done", 32'(done), 32'd0);

      // Second start while busy is ignored
      @(negedge clk);
      f3 = 3'd0; a = 32'd7; b = 32'hFFFF_FFFD; rd = 5'd5; start = 1'b1;
      seen = 0; when = -1; keep = '0;
      for (int k = 0; k <= 45; k++) begin
         @(negedge clk);
         start = (k == 9);
         if (k == 9) begin f3 = 3'd3; a = 32'd100; b = 32'd200; rd = 5'd9; end
         if (done) begin seen++; when = k; keep = result; end
      end
      start = 1'b0;
      check("busy_start_done_count", 32'(seen), 32'd1);
      check("busy_start_done_at", 32'(when), 32'd33);
      check("busy_start_result", keep, 32'hFFFF_FFEB);
      check("busy_start_rd", 32'(rd_out), 32'd5);

      // Abort mid-operation
      @(negedge clk);
      f3 = 3'd4; a = 32'd1000; b = 32'd3; rd = 5'd20; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      seen = 0;
      repeat (40) begin @(negedge clk); if (done) seen++; end
      check("abort_no_done", 32'(seen), 32'd0);
      check("abort_result_held", result, 32'hFFFF_FFEB);

      // Abort together with start in IDLE
      f3 = 3'd0; a = 32'd2; b = 32'd2; start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      check("abort_start_busy", 32'(busy), 32'd0);
      seen = 0;
      repeat (40) begin @(negedge clk); if (done) seen++; end
      check("abort_start_no_done", 32'(seen), 32'd0);

      // Asynchronous reset mid-divide
      f3 = 3'd4; a = 32'hFFFF_FFF9; b = 32'd2; rd = 5'd17; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("mid_reset_busy", 32'(busy), 32'd0);
      check("mid_reset_done", 32'(done), 32'd0);
      check("mid_reset_result", result, 32'd0);
      check("mid_reset_rd_out", 32'(rd_out), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (20) begin @(negedge clk); if (done) seen++; end
      check("mid_reset_no_done", 32'(seen), 32'd0);
      run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd17, res, rdo, lat);
      check("post_reset_result", res, 32'hFFFF_FFFD);
      check("post_reset_rd", 32'(rdo), 32'd17);
      check("post_reset_latency", 32'(lat), 32'd33);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
